// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: serial account lookup, PIN retry lockout, OTP gate on large
// debits and BALANCE/WITHDRAW/DEPOSIT/TRANSFER against an N-entry account table.
module atm_multi_account_ctrl #(
  parameter int NUM_ACC    = 8,
  parameter int ACC_W      = 12,
  parameter int PIN_W      = 4,
  parameter int BAL_W      = 11,
  parameter int OTP_W      = 4,
  parameter int INIT_BAL   = 500,
  parameter int MAX_TRIES  = 3,
  parameter int OTP_THRESH = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exit,
  input  logic                       card_valid,
  input  logic [ACC_W-1:0]           acc_num,
  input  logic                       pin_valid,
  input  logic [PIN_W-1:0]           pin,
  input  logic                       otp_valid,
  input  logic [OTP_W-1:0]           otp,
  input  logic                       op_valid,
  input  logic [1:0]                 op,
  input  logic [BAL_W-1:0]           amount,
  input  logic [ACC_W-1:0]           dest_acc,
  input  logic                       prov_we,
  input  logic [$clog2(NUM_ACC)-1:0] prov_idx,
  input  logic [ACC_W-1:0]           prov_acc,
  input  logic [PIN_W-1:0]           prov_pin,
  output logic                       busy,
  output logic                       session,
  output logic                       resp_valid,
  output logic                       error,
  output logic [2:0]                 err_code,
  output logic [BAL_W-1:0]           balance
);

  localparam int IDX_W = $clog2(NUM_ACC);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);
  localparam logic [BAL_W-1:0] THRESH   = BAL_W'(OTP_THRESH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FIND      = 3'd1;
  localparam logic [2:0] S_GET_PIN   = 3'd2;
  localparam logic [2:0] S_GET_OTP   = 3'd3;
  localparam logic [2:0] S_MENU      = 3'd4;
  localparam logic [2:0] S_FIND_DEST = 3'd5;
  localparam logic [2:0] S_EXEC      = 3'd6;

  localparam logic [1:0] OP_BAL = 2'd0;
  localparam logic [1:0] OP_DEP = 2'd2;
  localparam logic [1:0] OP_XFR = 2'd3;

  localparam logic [2:0] E_OK       = 3'd0;
  localparam logic [2:0] E_NO_ACC   = 3'd1;
  localparam logic [2:0] E_BAD_PIN  = 3'd2;
  localparam logic [2:0] E_LOCKED   = 3'd3;
  localparam logic [2:0] E_BAD_OTP  = 3'd4;
  localparam logic [2:0] E_INSUFF   = 3'd5;
  localparam logic [2:0] E_OVERFLOW = 3'd6;
  localparam logic [2:0] E_BAD_DEST = 3'd7;

  logic [ACC_W-1:0] tbl_acc   [NUM_ACC];
  logic [PIN_W-1:0] tbl_pin   [NUM_ACC];
  logic [BAL_W-1:0] tbl_bal   [NUM_ACC];
  logic [TRY_W-1:0] tbl_tries [NUM_ACC];
  logic             tbl_lock  [NUM_ACC];

  logic [2:0]       state;
  logic [IDX_W-1:0] idx, sess_idx, dest_idx;
  logic [ACC_W-1:0] key_acc;   // card number during FIND, destination during FIND_DEST
  logic [1:0]       txn_op;
  logic [BAL_W-1:0] txn_amt;
  logic [OTP_W-1:0] txn_cnt;

  logic [ACC_W-1:0] acc_sel;
  logic [PIN_W-1:0] pin_sel;
  logic [BAL_W-1:0] sess_bal, dest_bal, sess_diff;
  logic [BAL_W:0]   sess_sum, dest_sum;
  logic             insuff, search_hit;
  logic [OTP_W-1:0] exp_otp;

  // NOTE: every always_comb output is assigned unconditionally, so no latch can form.
  always_comb begin
    acc_sel    = tbl_acc[sess_idx];
    pin_sel    = tbl_pin[sess_idx];
    sess_bal   = tbl_bal[sess_idx];
    dest_bal   = tbl_bal[dest_idx];
    sess_diff  = sess_bal - txn_amt;
    sess_sum   = {1'b0, sess_bal} + {1'b0, txn_amt};
    dest_sum   = {1'b0, dest_bal} + {1'b0, txn_amt};
    insuff     = txn_amt > sess_bal;
    search_hit = tbl_acc[idx] == key_acc;
    exp_otp    = acc_sel[OTP_W-1:0] ^ pin_sel[OTP_W-1:0] ^ txn_cnt;
    busy       = (state == S_FIND) || (state == S_FIND_DEST) || (state == S_EXEC);
    error      = |err_code;
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      sess_idx   <= '0;
      dest_idx   <= '0;
      key_acc    <= '0;
      txn_op     <= '0;
      txn_amt    <= '0;
      txn_cnt    <= '0;
      session    <= 1'b0;
      resp_valid <= 1'b0;
      err_code   <= E_OK;
      balance    <= '0;
      // NOTE: the table must come back to known contents on reset, so it is built from
      // resettable flops rather than an uninitialised memory.
      for (int k = 0; k < NUM_ACC; k++) begin
        tbl_acc[k]   <= ACC_W'(1000 + k);
        tbl_pin[k]   <= PIN_W'(k);
        tbl_bal[k]   <= BAL_W'(INIT_BAL);
        tbl_tries[k] <= '0;
        tbl_lock[k]  <= 1'b0;
      end
    end else begin
      resp_valid <= 1'b0;
      if (exit && state != S_IDLE) begin
        state   <= S_IDLE;
        session <= 1'b0;
        balance <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (prov_we && (int'(prov_idx) < NUM_ACC)) begin
              tbl_acc[prov_idx]   <= prov_acc;
              tbl_pin[prov_idx]   <= prov_pin;
              tbl_tries[prov_idx] <= '0;
              tbl_lock[prov_idx]  <= 1'b0;
            end
            if (card_valid) begin
              key_acc <= acc_num;
              idx     <= '0;
              state   <= S_FIND;
            end
          end
          S_FIND: begin
            if (search_hit) begin
              sess_idx   <= idx;
              resp_valid <= 1'b1;
              err_code   <= tbl_lock[idx] ? E_LOCKED : E_OK;
              state      <= tbl_lock[idx] ? S_IDLE : S_GET_PIN;
            end else if (idx == LAST_IDX) begin
              resp_valid <= 1'b1;
              err_code   <= E_NO_ACC;
              state      <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_GET_PIN: begin
            if (pin_valid) begin
              resp_valid <= 1'b1;
              if (pin == pin_sel) begin
                tbl_tries[sess_idx] <= '0;
                session             <= 1'b1;
                balance             <= sess_bal;
                err_code            <= E_OK;
                state               <= S_MENU;
              end else begin
                tbl_tries[sess_idx] <= tbl_tries[sess_idx] + 1'b1;
                if (tbl_tries[sess_idx] == TRY_W'(MAX_TRIES - 1)) begin
                  tbl_lock[sess_idx] <= 1'b1;
                  err_code           <= E_LOCKED;
                  state              <= S_IDLE;
                end else begin
                  err_code <= E_BAD_PIN;
                end
              end
            end
          end
          S_MENU: begin
            if (op_valid) begin
              txn_op  <= op;
              txn_amt <= amount;
              key_acc <= dest_acc;
              idx     <= '0;
              if (op == OP_BAL) begin
                resp_valid <= 1'b1;
                err_code   <= E_OK;
              end else if (op != OP_DEP && amount >= THRESH) begin
                state <= S_GET_OTP;
              end else begin
                state <= (op == OP_XFR) ? S_FIND_DEST : S_EXEC;
              end
            end
          end
          S_GET_OTP: begin
            if (otp_valid) begin
              if (otp == exp_otp) begin
                state <= (txn_op == OP_XFR) ? S_FIND_DEST : S_EXEC;
              end else begin
                resp_valid <= 1'b1;
                err_code   <= E_BAD_OTP;
                state      <= S_MENU;
              end
            end
          end
          S_FIND_DEST: begin
            if (search_hit && key_acc != acc_sel) begin
              dest_idx <= idx;
              state    <= S_EXEC;
            end else if (search_hit || idx == LAST_IDX) begin
              resp_valid <= 1'b1;
              err_code   <= E_BAD_DEST;
              state      <= S_MENU;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_EXEC: begin
            state      <= S_MENU;
            resp_valid <= 1'b1;
            // Errors leave the table, balance and transaction counter untouched.
            if (txn_op == OP_DEP) begin
              if (sess_sum[BAL_W]) begin
                err_code <= E_OVERFLOW;
              end else begin
                tbl_bal[sess_idx] <= sess_sum[BAL_W-1:0];
                balance           <= sess_sum[BAL_W-1:0];
                txn_cnt           <= txn_cnt + 1'b1;
                err_code          <= E_OK;
              end
            end else if (insuff) begin
              err_code <= E_INSUFF;
            end else if (txn_op == OP_XFR && dest_sum[BAL_W]) begin
              err_code <= E_OVERFLOW;
            end else begin
              tbl_bal[sess_idx] <= sess_diff;
              balance           <= sess_diff;
              if (txn_op == OP_XFR) tbl_bal[dest_idx] <= dest_sum[BAL_W-1:0];
              txn_cnt  <= txn_cnt + 1'b1;
              err_code <= E_OK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Bench for atm_multi_account_ctrl: directed vector table, multi-cycle exit/reset
// sequences, then random sessions checked against an account-level reference model.
module tb_atm_multi_account_ctrl;

  localparam int NUM_ACC = 8, ACC_W = 12, PIN_W = 4, BAL_W = 11, OTP_W = 4;
  localparam int INIT_BAL = 500, MAX_TRIES = 3, OTP_THRESH = 200;
  localparam int BAL_MAX = (1 << BAL_W) - 1;

  localparam int K_CARD = 0, K_PIN = 1, K_OP = 2, K_EXIT = 3, K_PROV = 4;
  localparam int E_OK = 0, E_NO_ACC = 1, E_BAD_PIN = 2, E_LOCKED = 3, E_BAD_OTP = 4;
  localparam int E_INSUFF = 5, E_OVERFLOW = 6, E_BAD_DEST = 7, NO_RESP = -1;

  logic clk = 1'b0;
  logic rst, exit, card_valid, pin_valid, otp_valid, op_valid, prov_we;
  logic [ACC_W-1:0] acc_num, dest_acc, prov_acc;
  logic [PIN_W-1:0] pin, prov_pin;
  logic [OTP_W-1:0] otp;
  logic [1:0]       op;
  logic [BAL_W-1:0] amount;
  logic [2:0]       prov_idx;
  logic             busy, session, resp_valid, error;
  logic [2:0]       err_code;
  logic [BAL_W-1:0] balance;

  atm_multi_account_ctrl dut (
    .clk(clk), .rst(rst), .exit(exit), .card_valid(card_valid), .acc_num(acc_num),
    .pin_valid(pin_valid), .pin(pin), .otp_valid(otp_valid), .otp(otp),
    .op_valid(op_valid), .op(op), .amount(amount), .dest_acc(dest_acc),
    .prov_we(prov_we), .prov_idx(prov_idx), .prov_acc(prov_acc), .prov_pin(prov_pin),
    .busy(busy), .session(session), .resp_valid(resp_valid), .error(error),
    .err_code(err_code), .balance(balance)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the account table as plain integers plus session bookkeeping.
  int m_acc[NUM_ACC], m_pin[NUM_ACC], m_bal[NUM_ACC], m_tries[NUM_ACC];
  bit m_lock[NUM_ACC];
  int m_cnt, m_mode, m_cur, m_sess, m_out_bal;   // m_mode: 0 idle, 1 awaiting PIN, 2 menu

  task automatic init_model();
    for (int k = 0; k < NUM_ACC; k++) begin
      m_acc[k] = 1000 + k; m_pin[k] = k % (1 << PIN_W); m_bal[k] = INIT_BAL;
      m_tries[k] = 0; m_lock[k] = 0;
    end
    m_cnt = 0; m_mode = 0; m_cur = 0; m_sess = 0; m_out_bal = 0;
  endtask

  function automatic int find(input int a);
    for (int k = 0; k < NUM_ACC; k++) if (m_acc[k] == a) return k;
    return -1;
  endfunction

  // Executes a debit/credit in the model; returns response code and latency after strobe.
  task automatic model_exec(input int o, input int amt, input int dst,
                            output int code, output int lat);
    int s, j;
    s = m_sess; code = E_OK; lat = 1; j = -1;
    if (o == 3) begin
      j = find(dst);
      if (j < 0) begin code = E_BAD_DEST; lat = NUM_ACC; return; end
      if (m_acc[j] == m_acc[s]) begin code = E_BAD_DEST; lat = j + 1; return; end
      lat = j + 2;
    end
    if (o == 2) begin
      if (m_bal[s] + amt > BAL_MAX) code = E_OVERFLOW;
      else m_bal[s] = m_bal[s] + amt;
    end else if (amt > m_bal[s]) begin
      code = E_INSUFF;
    end else if (o == 3 && m_bal[j] + amt > BAL_MAX) begin
      code = E_OVERFLOW;
    end else begin
      m_bal[s] = m_bal[s] - amt;
      if (o == 3) m_bal[j] = m_bal[j] + amt;
    end
    if (code == E_OK) begin
      m_cnt++;
      m_out_bal = m_bal[s];
    end
  endtask

  task automatic wait_resp(output bit got, output int lat);
    got = 0; lat = 0;
    for (int i = 0; i < 3 * NUM_ACC; i++) begin
      if (resp_valid) begin got = 1; lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic expect_quiet(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < NUM_ACC + 3; i++) begin
      if (resp_valid) seen = 1;
      @(negedge clk);
    end
    check(name, seen, 0);
  endtask

  // One front-panel action: drive it, predict with the model, compare the response.
  task automatic step(input int kind, input int a, input int b, input int c, input int d,
                      output int got_code, output int got_bal);
    bit exp_resp, got;
    int exp_code, exp_lat, lat, ix, otpv;
    exp_resp = 0; exp_code = E_OK; exp_lat = 0; got_code = NO_RESP; got_bal = 0;
    case (kind)
      K_CARD: begin
        card_valid = 1; acc_num = ACC_W'(a);
        @(negedge clk); card_valid = 0;
        if (m_mode == 0) begin
          exp_resp = 1; ix = find(a);
          if (ix < 0) begin exp_code = E_NO_ACC; exp_lat = NUM_ACC; end
          else begin
            exp_lat = ix + 1;
            if (m_lock[ix]) exp_code = E_LOCKED;
            else begin m_mode = 1; m_cur = ix; end
          end
        end
      end
      K_PIN: begin
        pin_valid = 1; pin = PIN_W'(a);
        @(negedge clk); pin_valid = 0;
        if (m_mode == 1) begin
          exp_resp = 1;
          if (a == m_pin[m_cur]) begin
            m_tries[m_cur] = 0; m_mode = 2; m_sess = m_cur; m_out_bal = m_bal[m_cur];
          end else begin
            m_tries[m_cur]++;
            if (m_tries[m_cur] >= MAX_TRIES) begin
              m_lock[m_cur] = 1; m_mode = 0; exp_code = E_LOCKED;
            end else exp_code = E_BAD_PIN;
          end
        end
      end
      K_OP: begin
        op_valid = 1; op = 2'(a); amount = BAL_W'(b); dest_acc = ACC_W'(c);
        @(negedge clk); op_valid = 0;
        if (m_mode == 2) begin
          exp_resp = 1;
          if (a != 0) begin
            if (a != 2 && b >= OTP_THRESH) begin
              check("otp_pending_no_resp", resp_valid, 0);
              otpv = (m_acc[m_sess] ^ m_pin[m_sess] ^ m_cnt ^ d) % (1 << OTP_W);
              otp_valid = 1; otp = OTP_W'(otpv);
              @(negedge clk); otp_valid = 0;
            end else d = 0;
            if (d != 0) exp_code = E_BAD_OTP;
            else model_exec(a, b, c, exp_code, exp_lat);
          end
        end
      end
      K_EXIT: begin
        exit = 1;
        @(negedge clk); exit = 0;
        if (m_mode != 0) begin m_mode = 0; m_out_bal = 0; end
      end
      default: begin
        prov_we = 1; prov_idx = 3'(a); prov_acc = ACC_W'(b); prov_pin = PIN_W'(c);
        @(negedge clk); prov_we = 0;
        if (m_mode == 0) begin
          m_acc[a] = b; m_pin[a] = c; m_tries[a] = 0; m_lock[a] = 0;
        end
      end
    endcase
    if (exp_resp) begin
      wait_resp(got, lat);
      check("resp_seen", got, 1);
      if (got) begin
        got_code = err_code; got_bal = balance;
        check("resp_code", err_code, exp_code);
        check("resp_error", error, exp_code != E_OK);
        check("resp_latency", lat, exp_lat);
        check("resp_balance", balance, m_out_bal);
      end
    end else begin
      expect_quiet("no_resp");
    end
    check("session", session, m_mode == 2);
  endtask

  typedef struct {
    int kind; int a; int b; int c; int d; int code; int bal;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input int kind, a, b, c, d, code, bal);
    vec_t v;
    v.kind = kind; v.a = a; v.b = b; v.c = c; v.d = d; v.code = code; v.bal = bal;
    return v;
  endfunction

  int gc, gb, r, ai, st;
  bit gt;

  function automatic int rand_acc();
    if ($urandom_range(0, 4) != 0) return 1000 + $urandom_range(0, NUM_ACC - 1);
    return ($urandom_range(0, 3) == 0) ? 9999 : 1000 + $urandom_range(0, 11);
  endfunction

  initial begin
    rst = 1; exit = 0; card_valid = 0; pin_valid = 0; otp_valid = 0; op_valid = 0;
    prov_we = 0; acc_num = '0; dest_acc = '0; prov_acc = '0; pin = '0; prov_pin = '0;
    otp = '0; op = '0; amount = '0; prov_idx = '0;
    init_model();

    vecs.push_back(mk(K_CARD, 1003, 0, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_PIN,  3, 0, 0, 0, E_OK, 500));
    vecs.push_back(mk(K_EXIT, 0, 0, 0, 0, NO_RESP, 0));
    vecs.push_back(mk(K_CARD, 1002, 0, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_PIN,  5, 0, 0, 0, E_BAD_PIN, 0));
    vecs.push_back(mk(K_PIN,  5, 0, 0, 0, E_BAD_PIN, 0));
    vecs.push_back(mk(K_PIN,  5, 0, 0, 0, E_LOCKED, 0));
    vecs.push_back(mk(K_CARD, 1002, 0, 0, 0, E_LOCKED, 0));
    vecs.push_back(mk(K_PROV, 2, 1002, 2, 0, NO_RESP, 0));
    vecs.push_back(mk(K_CARD, 1002, 0, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_PIN,  2, 0, 0, 0, E_OK, 500));
    vecs.push_back(mk(K_EXIT, 0, 0, 0, 0, NO_RESP, 0));
    vecs.push_back(mk(K_CARD, 9999, 0, 0, 0, E_NO_ACC, 0));
    vecs.push_back(mk(K_CARD, 1003, 0, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_PIN,  3, 0, 0, 0, E_OK, 500));
    vecs.push_back(mk(K_OP,   1, 100, 0, 0, E_OK, 400));
    vecs.push_back(mk(K_OP,   1, 450, 0, 0, E_INSUFF, 400));
    vecs.push_back(mk(K_OP,   3, 50, 1006, 0, E_OK, 350));
    vecs.push_back(mk(K_EXIT, 0, 0, 0, 0, NO_RESP, 0));
    vecs.push_back(mk(K_CARD, 1006, 0, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_PIN,  6, 0, 0, 0, E_OK, 550));
    vecs.push_back(mk(K_OP,   3, 10, 1006, 0, E_BAD_DEST, 550));
    vecs.push_back(mk(K_OP,   2, 1600, 0, 0, E_OVERFLOW, 550));
    vecs.push_back(mk(K_OP,   1, 300, 0, 5, E_BAD_OTP, 550));
    vecs.push_back(mk(K_OP,   0, 0, 0, 0, E_OK, 550));
    vecs.push_back(mk(K_OP,   2, 0, 0, 0, E_OK, 550));
    vecs.push_back(mk(K_OP,   2, 1497, 0, 0, E_OK, 2047));
    vecs.push_back(mk(K_OP,   1, 2047, 0, 0, E_OK, 0));
    vecs.push_back(mk(K_OP,   1, 199, 0, 0, E_INSUFF, 0));
    vecs.push_back(mk(K_PIN,  6, 0, 0, 0, NO_RESP, 0));
    vecs.push_back(mk(K_OP,   3, 250, 1003, 0, E_INSUFF, 0));

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_session", session, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_balance", balance, 0);
    rst = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, gc, gb);
      check($sformatf("vec%0d_code", i), gc, vecs[i].code);
      if (vecs[i].code != NO_RESP) check($sformatf("vec%0d_balance", i), gb, vecs[i].bal);
    end

    // Exit while a deposit sits in EXEC: the credit must be abandoned.
    op_valid = 1; op = 2'd2; amount = BAL_W'(100);
    @(negedge clk); op_valid = 0;
    check("exec_busy", busy, 1);
    exit = 1;
    @(negedge clk); exit = 0;
    m_mode = 0; m_out_bal = 0;
    check("exit_exec_session", session, 0);
    check("exit_exec_balance", balance, 0);
    expect_quiet("exit_exec_no_resp");
    check("exit_exec_idle_busy", busy, 0);
    step(K_CARD, 1006, 0, 0, 0, gc, gb);
    step(K_PIN, 6, 0, 0, 0, gc, gb);
    check("exec_abort_balance", gb, 0);
    step(K_OP, 2, 300, 0, 0, gc, gb);
    check("deposit_after_abort", gb, 300);

    // Exit while the transfer destination is still being searched.
    op_valid = 1; op = 2'd3; amount = BAL_W'(20); dest_acc = ACC_W'(1007);
    @(negedge clk); op_valid = 0;
    @(negedge clk);
    check("find_dest_busy", busy, 1);
    exit = 1;
    @(negedge clk); exit = 0;
    m_mode = 0; m_out_bal = 0;
    check("exit_dest_session", session, 0);
    expect_quiet("exit_dest_no_resp");
    step(K_CARD, 1007, 0, 0, 0, gc, gb);
    step(K_PIN, 7, 0, 0, 0, gc, gb);
    check("dest_untouched", gb, 500);

    // Reset in the middle of a session re-initialises the whole table.
    step(K_OP, 2, 123, 0, 0, gc, gb);
    rst = 1;
    @(negedge clk);
    check("midrst_session", session, 0);
    check("midrst_balance", balance, 0);
    @(negedge clk); rst = 0;
    init_model();
    @(negedge clk);
    step(K_CARD, 1007, 0, 0, 0, gc, gb);
    step(K_PIN, 7, 0, 0, 0, gc, gb);
    check("midrst_table_reinit", gb, INIT_BAL);
    step(K_EXIT, 0, 0, 0, 0, gc, gb);

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      case (m_mode)
        0: begin
          if (r < 65) step(K_CARD, rand_acc(), 0, 0, 0, gc, gb);
          else if (r < 78) begin
            ai = $urandom_range(0, NUM_ACC - 1);
            step(K_PROV, ai, 1000 + $urandom_range(0, 9), $urandom_range(0, 15), 0, gc, gb);
          end
          else if (r < 84) step(K_PIN, $urandom_range(0, 15), 0, 0, 0, gc, gb);
          else if (r < 90) step(K_OP, $urandom_range(0, 3), $urandom_range(0, 300), rand_acc(), 0, gc, gb);
          else step(K_EXIT, 0, 0, 0, 0, gc, gb);
        end
        1: begin
          if (r < 55) step(K_PIN, m_pin[m_cur], 0, 0, 0, gc, gb);
          else if (r < 90) step(K_PIN, $urandom_range(0, 15), 0, 0, 0, gc, gb);
          else step(K_EXIT, 0, 0, 0, 0, gc, gb);
        end
        default: begin
          if (r < 85) begin
            st = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom_range(0, BAL_MAX);
            ai = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0;
            step(K_OP, $urandom_range(0, 3), st, rand_acc(), ai, gc, gb);
          end
          else if (r < 92) step(K_EXIT, 0, 0, 0, 0, gc, gb);
          else step(K_CARD, rand_acc(), 0, 0, 0, gc, gb);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
